uart_wb_bridge: RTL and testbench
=================================

# uart_wb_bridge

Wishbone slave front-end for the UART register file. Converts 32-bit classic Wishbone cycles into single-cycle byte-wide register strobes (`reg_we_o` / `reg_re_o`) and returns the register file's registered read byte on the correct lane. It sits directly upstream of the register block. It guarantees exactly one read strobe per bus read, because reads of RB, LS, MS and II have side effects.

## Interface
Parameters:
- `ADDR_WIDTH`, default 3: register address width; equals `UART_ADDR_WIDTH`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `wb_rst_i`  in  1  reset; synchronous, active-low. Sampled only on the `clk` rising edge.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_adr_i`  in  ADDR_WIDTH  byte address; bits [1:0] are ignored (lane comes from `wb_sel_i`).
- `wb_sel_i`  in  4  byte-lane select; little-endian (lane 0 = bits [7:0]).
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data.
- `wb_ack_o`  out  1  normal termination.
- `wb_err_o`  out  1  error termination.
- `reg_addr_o`  out  ADDR_WIDTH  register address.
- `reg_dat_o`  out  8  register write byte.
- `reg_dat_i`  in  8  register read byte; registered by the register file, valid the cycle after `reg_re_o`.
- `reg_we_o`  out  1  one-cycle write strobe.
- `reg_re_o`  out  1  one-cycle read strobe.

## Operation
- All outputs are registered. Reset values: `wb_dat_o` = 0, `wb_ack_o` = 0, `wb_err_o` = 0, `reg_addr_o` = 0, `reg_dat_o` = 0, `reg_we_o` = 0, `reg_re_o` = 0. The FSM resets to IDLE.
- FSM states: IDLE, W_STB, R_STB, R_WAIT, ACK, ERR.
- **IDLE**
  - If `wb_cyc_i & wb_stb_i` and `wb_sel_i` is one-hot: compute lane index L (0..3) and latch `reg_addr_o` = {`wb_adr_i`[ADDR_WIDTH-1:2], L}.
    - Write: latch `reg_dat_o` = lane L of `wb_dat_i`, go to W_STB.
    - Read: go to R_STB.
  - If `wb_sel_i` is 0 or has more than one bit set: go to ERR. No register strobe is issued.
- **W_STB:** `reg_we_o` = 1 for this cycle only, then go to ACK.
- **R_STB:** `reg_re_o` = 1 for this cycle only, then go to R_WAIT.
- **R_WAIT:** capture `reg_dat_i` into lane L of `wb_dat_o`; all other lanes = 0. Go to ACK.
- **ACK:** `wb_ack_o` = 1 for exactly one cycle. On exit, `wb_dat_o` is cleared to 0 and the FSM returns to IDLE.
- **ERR:** `wb_err_o` = 1 for exactly one cycle, `wb_dat_o` = 0, then go to IDLE.
- `reg_dat_o` and `reg_addr_o` hold their values until the next accepted request.
- Abort: `wb_cyc_i` = 0 while in W_STB, R_STB, R_WAIT, ACK or ERR:
  - Go to IDLE at the next edge; `wb_ack_o` / `wb_err_o` are not asserted.
  - A strobe already in progress completes its single cycle. No strobe is ever repeated or issued after the abort.
- `wb_stb_i` is ignored outside IDLE. The bus is not pipelined: at most one transaction is outstanding.
- Reset mid-transaction: at the reset edge all outputs return to reset values and the FSM goes to IDLE. The pending access is dropped with no strobe.

## Timing
- The request is sampled at edge k, in IDLE.
- Write:
  - `reg_we_o` high during cycle k+1.
  - `wb_ack_o` high during cycle k+2 (ack latency 2).
- Read:
  - `reg_re_o` high during cycle k+1.
  - `reg_dat_i` valid during cycle k+2.
  - `wb_ack_o` high during cycle k+3, with `wb_dat_o` valid in the same cycle (ack latency 3).
- Error: `wb_err_o` high during cycle k+1.
- `wb_ack_o` and `wb_err_o` are never high together. At most one of `reg_we_o` / `reg_re_o` is high in any cycle.
- Back-to-back: after ACK the FSM is in IDLE and can accept a new strobe one cycle later. Minimum spacing between strobes is 3 cycles (write) or 4 cycles (read).

## Test plan
- Write, address 3, `wb_sel_i` = 4'b1000, `wb_dat_i` = 32'h1B00_0000:
  - `reg_we_o` pulse in cycle k+1 with `reg_addr_o` = 3, `reg_dat_o` = 8'h1B.
  - `wb_ack_o` in cycle k+2.
  - No `reg_re_o`.
- Read, address 5, `wb_sel_i` = 4'b0010, register returns 8'h60:
  - Exactly one `reg_re_o` (cycle k+1), `reg_addr_o` = 5.
  - `wb_ack_o` in cycle k+3 with `wb_dat_o` = 32'h0000_6000.
  - `wb_dat_o` = 0 the following cycle.
- Invalid select, `wb_sel_i` = 4'b0011 and 4'b0000, read and write:
  - `wb_err_o` for one cycle at k+1.
  - No `reg_we_o` / `reg_re_o`, no `wb_ack_o`.
- Abort: read started, `wb_cyc_i` dropped during R_WAIT:
  - Single `reg_re_o` only, no `wb_ack_o`.
  - FSM idle; the next read completes normally.
- Reset: `wb_rst_i` = 0 held for one edge during W_STB:
  - All outputs 0 at the following cycle, FSM in IDLE.
  - A write started after reset release acks at k+2.
- Back-to-back: 8 alternating read/write cycles with the master holding `wb_stb_i` until ack:
  - Exactly one register strobe per bus cycle.
  - Every transaction is acked at its stated latency.

Source files
------------

// File: rtl/uart_wb_bridge.sv
// Wishbone (classic, 32-bit) slave front-end for the UART register file.
// Turns each bus cycle into exactly one byte-wide register strobe and returns
// the register file's registered read byte on the selected lane.
module uart_wb_bridge #(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [7:0]            reg_dat_o,
  input  logic [7:0]            reg_dat_i,
  output logic                  reg_we_o,
  output logic                  reg_re_o
);

  typedef enum logic [2:0] {
    IDLE,
    W_STB,
    R_STB,
    R_WAIT,
    ACK,
    ERR
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [31:0]             dat_nxt;
  logic                    ack_nxt;
  logic                    err_nxt;
  logic                    we_nxt;
  logic                    re_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [7:0]              wdat_nxt;
  logic                    sel_onehot;
  logic [1:0]              lane;

  // Decode the byte-lane select into a lane index and a one-hot validity flag.
  always_comb begin
    sel_onehot = (wb_sel_i != 4'b0000) && ((wb_sel_i & (wb_sel_i - 4'd1)) == 4'b0000);
    case (wb_sel_i)
      4'b0010: lane = 2'd1;
      4'b0100: lane = 2'd2;
      4'b1000: lane = 2'd3;
      default: lane = 2'd0;
    endcase
  end

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so that the registered outputs line up with the state they belong to.
  always_comb begin
    state_nxt = state;
    dat_nxt   = '0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    we_nxt    = 1'b0;
    re_nxt    = 1'b0;
    addr_nxt  = reg_addr_o;
    wdat_nxt  = reg_dat_o;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (sel_onehot) begin
            // Word address from the bus, low two bits replaced by the lane.
            addr_nxt      = wb_adr_i;
            addr_nxt[1:0] = lane;
            if (wb_we_i) begin
              wdat_nxt  = wb_dat_i[{lane, 3'b000} +: 8];
              we_nxt    = 1'b1;
              state_nxt = W_STB;
            end else begin
              re_nxt    = 1'b1;
              state_nxt = R_STB;
            end
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ERR;
          end
        end
      end
      W_STB: begin
        if (wb_cyc_i) begin
          ack_nxt   = 1'b1;
          state_nxt = ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      R_STB: begin
        state_nxt = wb_cyc_i ? R_WAIT : IDLE;
      end
      R_WAIT: begin
        if (wb_cyc_i) begin
          // The lane index is still held in the low address bits.
          dat_nxt[{reg_addr_o[1:0], 3'b000} +: 8] = reg_dat_i;
          ack_nxt   = 1'b1;
          state_nxt = ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACK:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!wb_rst_i) begin
      state      <= IDLE;
      wb_dat_o   <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      reg_addr_o <= '0;
      reg_dat_o  <= '0;
      reg_we_o   <= 1'b0;
      reg_re_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wb_dat_o   <= dat_nxt;
      wb_ack_o   <= ack_nxt;
      wb_err_o   <= err_nxt;
      reg_addr_o <= addr_nxt;
      reg_dat_o  <= wdat_nxt;
      reg_we_o   <= we_nxt;
      reg_re_o   <= re_nxt;
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: the driver predicts every strobe, ack
// and error (kind, cycle, payload) into a queue; a monitor process pops and
// compares whenever the bridge presents one of those outputs.
module tb_uart_wb_bridge;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic [AW-1:0] reg_addr_o;
  logic [7:0]    reg_dat_o;
  logic [7:0]    reg_dat_i;
  logic          reg_we_o;
  logic          reg_re_o;

  always #5 clk = ~clk;

  uart_wb_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .reg_addr_o (reg_addr_o),
    .reg_dat_o  (reg_dat_o),
    .reg_dat_i  (reg_dat_i),
    .reg_we_o   (reg_we_o),
    .reg_re_o   (reg_re_o)
  );

  // Register file stand-in: registered read byte valid the cycle after the
  // read strobe, junk at all other times.
  logic [7:0] mem [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h60, 8'h77, 8'h88};
  always @(posedge clk) begin
    if (reg_we_o) mem[reg_addr_o] <= reg_dat_o;
    if (reg_re_o) reg_dat_i <= mem[reg_addr_o];
    else          reg_dat_i <= 8'($urandom);
  end

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef enum int {EV_WSTB = 0, EV_RSTB = 1, EV_ACK = 2, EV_ERR = 3} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] bdat;
    logic [31:0] rdat;
  } ev_t;

  ev_t         exq[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          mon_en      = 1'b0;

  // Reference model state: register contents and the held address/write byte.
  logic [7:0]  shadow [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h60, 8'h77, 8'h88};
  logic [31:0] last_addr;
  logic [31:0] last_wdat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, got, exp, edge_cnt + 1);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_bus;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'b0000;
  endtask

  task automatic push(input ev_kind_t kind, input int unsigned cyc, input logic [31:0] addr,
                      input logic [31:0] bdat, input logic [31:0] rdat);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.addr = addr; e.bdat = bdat; e.rdat = rdat;
    exq.push_back(e);
  endtask

  // One bus transaction. abort_at > 0 drops wb_cyc_i after that many edges.
  task automatic do_txn(input bit w, input logic [AW-1:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int unsigned abort_at);
    int unsigned k;
    int unsigned lane;
    logic [31:0] a;
    logic [31:0] b;
    bit          got;
    k = edge_cnt + 1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    if ($countones(sel) != 1) begin
      push(EV_ERR, k + 1, last_addr, last_wdat, 0);
    end else begin
      lane = 0;
      for (int i = 0; i < 4; i++) if (sel[i]) lane = i;
      a = {{(32-AW){1'b0}}, adr};
      a[1:0] = 2'(lane);
      if (w) begin
        b = (dat >> (8 * lane)) & 32'hFF;
        push(EV_WSTB, k + 1, a, b, 0);
        shadow[a[2:0]] = b[7:0];
        last_wdat = b;
        if (abort_at == 0) push(EV_ACK, k + 2, 0, 0, 0);
      end else begin
        push(EV_RSTB, k + 1, a, last_wdat, 0);
        if (abort_at == 0) push(EV_ACK, k + 3, 0, 0, {24'h0, shadow[a[2:0]]} << (8 * lane));
      end
      last_addr = a;
    end
    if (abort_at != 0) begin
      repeat (abort_at) tick;
      idle_bus;
      tick;
    end else begin
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        tick;
        if (wb_ack_o || wb_err_o) got = 1'b1;
      end
      if (!got) begin
        vectors++;
        miscompares++;
        $display("FAIL termination_timeout: actual none required ack/err (request at %0d)", k);
      end
      tick;
      idle_bus;
    end
  endtask

  task automatic chk_reset_outputs;
    chk("rst_wb_dat_o",   wb_dat_o, 0);
    chk("rst_wb_ack_o",   {31'b0, wb_ack_o}, 0);
    chk("rst_wb_err_o",   {31'b0, wb_err_o}, 0);
    chk("rst_reg_addr_o", {{(32-AW){1'b0}}, reg_addr_o}, 0);
    chk("rst_reg_dat_o",  {24'b0, reg_dat_o}, 0);
    chk("rst_reg_we_o",   {31'b0, reg_we_o}, 0);
    chk("rst_reg_re_o",   {31'b0, reg_re_o}, 0);
  endtask

  initial begin
    ev_t         e;
    ev_kind_t    ak;
    int unsigned nev;
    int unsigned k;
    logic [3:0]  sel;
    bit          w;

    idle_bus;
    wb_rst_i = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;

    // Monitor: pops and compares on every strobe/ack/err the bridge presents.
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          nev = 0;
          if (reg_we_o) nev++;
          if (reg_re_o) nev++;
          if (wb_ack_o) nev++;
          if (wb_err_o) nev++;
          chk("exclusive_outputs", nev > 1 ? 32'd1 : 32'd0, 0);
          if (!wb_ack_o) chk("dat_o_idle_zero", wb_dat_o, 0);
          if (nev != 0) begin
            ak = reg_we_o ? EV_WSTB : reg_re_o ? EV_RSTB : wb_ack_o ? EV_ACK : EV_ERR;
            if (exq.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_event: actual kind %0d required none (cycle %0d)",
                       int'(ak), edge_cnt + 1);
            end else begin
              e = exq.pop_front();
              chk("event_kind", 32'(ak), 32'(e.kind));
              chk("event_cycle", edge_cnt + 1, e.cyc);
              if (ak == e.kind) begin
                case (e.kind)
                  EV_WSTB, EV_RSTB, EV_ERR: begin
                    chk("reg_addr_o", {{(32-AW){1'b0}}, reg_addr_o}, e.addr);
                    chk("reg_dat_o", {24'b0, reg_dat_o}, e.bdat);
                  end
                  default: chk("ack_wb_dat_o", wb_dat_o, e.rdat);
                endcase
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs;
    wb_rst_i  = 1'b1;
    last_addr = 0;
    last_wdat = 0;
    mon_en    = 1'b1;
    tick;

    // Single write on lane 3, then a read on lane 1.
    do_txn(1'b1, 3'd3, 4'b1000, 32'h1B00_0000, 0);
    do_txn(1'b0, 3'd5, 4'b0010, 32'h0, 0);

    // Invalid selects: reads and writes.
    do_txn(1'b0, 3'd1, 4'b0011, 32'hDEAD_BEEF, 0);
    do_txn(1'b1, 3'd1, 4'b0011, 32'hDEAD_BEEF, 0);
    do_txn(1'b0, 3'd2, 4'b0000, 32'hCAFE_F00D, 0);
    do_txn(1'b1, 3'd2, 4'b0000, 32'hCAFE_F00D, 0);

    // Read aborted in R_WAIT, then the same read completes normally.
    do_txn(1'b0, 3'd6, 4'b0100, 32'h0, 2);
    do_txn(1'b0, 3'd6, 4'b0100, 32'h0, 0);

    // Reset held for one edge while the write strobe is out.
    k = edge_cnt + 1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 3'd2; wb_sel_i = 4'b0001; wb_dat_i = 32'h0000_00A5;
    push(EV_WSTB, k + 1, 32'd0, 32'hA5, 0);
    shadow[0] = 8'hA5;
    tick;
    wb_rst_i = 1'b0;
    idle_bus;
    tick;
    wb_rst_i = 1'b1;
    chk_reset_outputs;
    last_addr = 0;
    last_wdat = 0;
    do_txn(1'b1, 3'd7, 4'b0100, 32'h00C3_0000, 0);
    do_txn(1'b0, 3'd0, 4'b0001, 32'h0, 0);

    // Back-to-back alternating reads and writes.
    for (int i = 0; i < 8; i++)
      do_txn(i[0], AW'($urandom), 4'b0001 << $urandom_range(0, 3), $urandom, 0);

    // Randomized mix of valid, invalid and aborted accesses.
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        do sel = 4'($urandom); while ($countones(sel) == 1);
        do_txn(w, AW'($urandom), sel, $urandom, 0);
      end else begin
        sel = 4'b0001 << $urandom_range(0, 3);
        do_txn(w, AW'($urandom), sel, $urandom,
               ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0);
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick;
    end

    repeat (6) tick;
    mon_en = 1'b0;
    while (exq.size() != 0) begin
      e = exq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: actual none required kind %0d at cycle %0d",
               int'(e.kind), e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
